// File: rtl/multi_hold_handler.sv
// multi_hold_handler: NUM_SLOTS addressable hold slots with a per-piece hold budget.
// Emits registered bag_fetch / hold_swap / hold_reject pulses for the spawner.
module multi_hold_handler #(
   parameter int NUM_SLOTS = 2,
   parameter int HOLDS_PER_DROP = 1,
   parameter int TYPE_W = 3,
   parameter logic [TYPE_W-1:0] BLANK_VAL = '0,
   localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   localparam int CNT_W = $clog2(HOLDS_PER_DROP + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        game_start,
   input  logic                        new_tetromino,
   input  logic                        hold_input,
   input  logic [SEL_W-1:0]            slot_sel,
   input  logic [TYPE_W-1:0]           falling_type,
   output logic                        hold_valid,
   output logic [CNT_W-1:0]            holds_left,
   output logic                        bag_fetch,
   output logic                        hold_swap,
   output logic [TYPE_W-1:0]           swap_type,
   output logic                        hold_reject,
   output logic [NUM_SLOTS*TYPE_W-1:0] hold_types
);
   logic [NUM_SLOTS-1:0][TYPE_W-1:0] slots_q, slots_d;
   logic [CNT_W-1:0]  used_q, used_d;
   logic              bag_fetch_q, bag_fetch_d, hold_swap_q, hold_swap_d, hold_reject_q, hold_reject_d;
   logic [TYPE_W-1:0] swap_type_q, swap_type_d, old_type;
   logic              hit, accept;

   assign hold_valid  = used_q < CNT_W'(HOLDS_PER_DROP);
   assign holds_left  = CNT_W'(HOLDS_PER_DROP) - used_q;
   assign bag_fetch   = bag_fetch_q;
   assign hold_swap   = hold_swap_q;
   assign hold_reject = hold_reject_q;
   assign swap_type   = swap_type_q;
   assign hold_types  = slots_q;

   // Out-of-range selects simply never hit, so no slot is read or written.
   always_comb begin
      hit = 1'b0;
      old_type = BLANK_VAL;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (slot_sel == SEL_W'(i)) begin
            hit = 1'b1;
            old_type = slots_q[i];
         end
      end
   end

   assign accept = hold_input && hold_valid && hit && falling_type != BLANK_VAL && !game_start && !new_tetromino;

   always_comb begin
      slots_d = slots_q;
      used_d = used_q;
      swap_type_d = swap_type_q;
      bag_fetch_d = 1'b0;
      hold_swap_d = 1'b0;
      hold_reject_d = hold_input && !accept && !game_start;
      if (game_start) begin
         for (int i = 0; i < NUM_SLOTS; i++) slots_d[i] = BLANK_VAL;
         used_d = '0;
         swap_type_d = BLANK_VAL;
      end else if (new_tetromino) begin
         used_d = '0;
      end else if (accept) begin
         for (int i = 0; i < NUM_SLOTS; i++)
            if (slot_sel == SEL_W'(i)) slots_d[i] = falling_type;
         used_d = used_q + CNT_W'(1);
         bag_fetch_d = old_type == BLANK_VAL;
         hold_swap_d = old_type != BLANK_VAL;
         swap_type_d = (old_type != BLANK_VAL) ? old_type : swap_type_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= BLANK_VAL;
         used_q <= '0;
         swap_type_q <= BLANK_VAL;
         bag_fetch_q <= 1'b0;
         hold_swap_q <= 1'b0;
         hold_reject_q <= 1'b0;
      end else begin
         slots_q <= slots_d;
         used_q <= used_d;
         swap_type_q <= swap_type_d;
         bag_fetch_q <= bag_fetch_d;
         hold_swap_q <= hold_swap_d;
         hold_reject_q <= hold_reject_d;
      end
   end
endmodule

// File: tb/tb_multi_hold_handler.sv
// tb_multi_hold_handler: directed checks on a 2-slot/1-hold and a 3-slot/2-hold instance.
module tb_multi_hold_handler;
   logic clk = 1'b0, rst = 1'b0, gs = 1'b0, nt = 1'b0, hi = 1'b0;
   logic [1:0] sel = '0;
   logic [2:0] ft = '0;
   logic hv0, bf0, hs0, hr0, hv1, bf1, hs1, hr1;
   logic hl0;
   logic [1:0] hl1;
   logic [2:0] st0, st1;
   logic [5:0] ht0;
   logic [8:0] ht1;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   multi_hold_handler u0 (
      .clk(clk), .rst(rst), .game_start(gs), .new_tetromino(nt), .hold_input(hi),
      .slot_sel(sel[0:0]), .falling_type(ft), .hold_valid(hv0), .holds_left(hl0),
      .bag_fetch(bf0), .hold_swap(hs0), .swap_type(st0), .hold_reject(hr0), .hold_types(ht0));

   multi_hold_handler #(.NUM_SLOTS(3), .HOLDS_PER_DROP(2)) u1 (
      .clk(clk), .rst(rst), .game_start(gs), .new_tetromino(nt), .hold_input(hi),
      .slot_sel(sel), .falling_type(ft), .hold_valid(hv1), .holds_left(hl1),
      .bag_fetch(bf1), .hold_swap(hs1), .swap_type(st1), .hold_reject(hr1), .hold_types(ht1));

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic g, input logic n, input logic h, input logic [1:0] s, input logic [2:0] f);
      rst = r; gs = g; nt = n; hi = h; sel = s; ft = f;
      @(posedge clk);
      #1;
      rst = 0; gs = 0; nt = 0; hi = 0; sel = 0; ft = 0;
   endtask

   initial begin
      @(negedge clk);
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_hv0", hv0, 1); chk("rst_hl0", hl0, 1); chk("rst_ht0", ht0, 0);
      chk("rst_bf0", bf0, 0); chk("rst_hr0", hr0, 0); chk("rst_st0", st0, 0);
      chk("rst_hl1", hl1, 2); chk("rst_ht1", ht1, 0);
      // Instance 0: one hold per drop
      cyc(0, 0, 0, 1, 0, 5);
      chk("t1_bf", bf0, 1); chk("t1_hs", hs0, 0); chk("t1_ht", ht0, 5);
      chk("t1_hv", hv0, 0); chk("t1_hl", hl0, 0);
      cyc(0, 0, 0, 1, 0, 2);
      chk("t1_rej", hr0, 1); chk("t1_rej_bf", bf0, 0); chk("t1_rej_ht", ht0, 5);
      cyc(0, 0, 1, 0, 0, 0);
      chk("t2_nt_hv", hv0, 1); chk("t2_nt_hr", hr0, 0);
      cyc(0, 0, 0, 1, 0, 1);
      chk("t2_hs", hs0, 1); chk("t2_bf", bf0, 0); chk("t2_st", st0, 5); chk("t2_ht", ht0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t2_pulse_end", hs0, 0); chk("t2_st_keep", st0, 5);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 1, 1, 3);
      chk("t6_bf", bf0, 0); chk("t6_ht", ht0, 0); chk("t6_st", st0, 0); chk("t6_hv", hv0, 1);
      chk("t6_ht1", ht1, 0); chk("t6_hl1", hl1, 2);
      // Instance 1: three slots, two holds per drop
      cyc(0, 0, 0, 1, 0, 3);
      chk("t3_bf_a", bf1, 1); chk("t3_hl_a", hl1, 1); chk("t3_ht_a", ht1, 3);
      cyc(0, 0, 0, 1, 1, 4);
      chk("t3_bf_b", bf1, 1); chk("t3_hl_b", hl1, 0); chk("t3_hv_b", hv1, 0); chk("t3_ht_b", ht1, 35);
      cyc(0, 0, 0, 1, 2, 6);
      chk("t3_rej", hr1, 1); chk("t3_rej_bf", bf1, 0); chk("t3_rej_ht", ht1, 35);
      cyc(0, 0, 1, 0, 0, 0);
      chk("t4_nt_hl", hl1, 2);
      cyc(0, 0, 1, 1, 2, 6);
      chk("t4_nt_rej", hr1, 1); chk("t4_nt_hl2", hl1, 2); chk("t4_nt_ht", ht1, 35);
      cyc(0, 0, 0, 1, 2, 0);
      chk("t4_blank_rej", hr1, 1); chk("t4_blank_ht", ht1, 35);
      cyc(0, 0, 0, 1, 3, 6);
      chk("t4_sel_rej", hr1, 1); chk("t4_sel_hl", hl1, 2); chk("t4_sel_ht", ht1, 35);
      cyc(0, 0, 0, 1, 0, 6);
      chk("rep_hs_a", hs1, 1); chk("rep_st_a", st1, 3); chk("rep_ht_a", ht1, 38); chk("rep_hl_a", hl1, 1);
      cyc(0, 0, 0, 1, 0, 2);
      chk("rep_hs_b", hs1, 1); chk("rep_st_b", st1, 6); chk("rep_ht_b", ht1, 34); chk("rep_hl_b", hl1, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 6);
      chk("t5_load_st", st1, 4); chk("t5_load_ht", ht1, 50);
      cyc(0, 1, 0, 1, 0, 5);
      chk("t5_ht", ht1, 0); chk("t5_hl", hl1, 2); chk("t5_hv", hv1, 1);
      chk("t5_bf", bf1, 0); chk("t5_hs", hs1, 0); chk("t5_hr", hr1, 0); chk("t5_st", st1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multi_hold_handler.md
Name: multi_hold_handler

Overview:
Parametrised successor to the single-slot hold logic. Provides NUM_SLOTS independently addressable hold slots and allows up to HOLDS_PER_DROP hold operations per falling piece. Sits between the input decoder and the piece bag/spawn logic. Emits registered bag-fetch and swap pulses that tell the spawner where the next falling piece comes from.

Parameters:
NUM_SLOTS, 2, number of hold slots (>=1)
HOLDS_PER_DROP, 1, hold operations permitted between consecutive new_tetromino events (>=1)
TYPE_W, 3, width of a tile type code (matches tile_type_t)
BLANK_VAL, 0, type code meaning empty slot (matches BLANK)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
game_start  input  1  clears all slots and counters
new_tetromino  input  1  a new falling piece spawned after lock; re-arms hold budget
hold_input  input  1  hold request, single-cycle pulse
slot_sel  input  SEL_W=max(1,$clog2(NUM_SLOTS))  target slot of the hold request
falling_type  input  TYPE_W  type of the current falling piece
hold_valid  output  1  high when a hold would currently be accepted (budget remaining)
holds_left  output  CNT_W=$clog2(HOLDS_PER_DROP+1)  remaining holds for this piece
bag_fetch  output  1  registered pulse: held into an empty slot, spawn from bag
hold_swap  output  1  registered pulse: held into an occupied slot, spawn swap_type
swap_type  output  TYPE_W  previous slot contents; valid with hold_swap
hold_reject  output  1  registered pulse: hold_input arrived but was refused
hold_types  output  NUM_SLOTS*TYPE_W  slot contents, slot i at [i*TYPE_W +: TYPE_W]

Behaviour:
- Single clock domain. All state updates on posedge clk. rst is sampled synchronously and overrides every other input.
- Reset / game_start values (identical):
  - every slot = BLANK_VAL
  - used counter = 0, so holds_left = HOLDS_PER_DROP and hold_valid = 1
  - bag_fetch, hold_swap and hold_reject = 0
  - swap_type = BLANK_VAL
- hold_valid = (used < HOLDS_PER_DROP). holds_left = HOLDS_PER_DROP - used. Both are combinational from the counter.
- Acceptance, evaluated in cycle N. A hold is accepted iff all of the following hold:
  - hold_input = 1
  - hold_valid = 1
  - slot_sel < NUM_SLOTS
  - falling_type != BLANK_VAL
  - game_start = 0
  - new_tetromino = 0
- On acceptance, at edge N+1:
  - slot[slot_sel] <= falling_type
  - used <= used + 1
  - if the old slot was BLANK_VAL: bag_fetch = 1 in cycle N+1
  - otherwise: hold_swap = 1 in cycle N+1 and swap_type = old slot value
  - Pulses last exactly one cycle. swap_type holds its value until the next swap or reset.
- Rejection: if hold_input = 1 but the request is not accepted, hold_reject = 1 in cycle N+1 and no state changes. Exception: game_start takes effect and suppresses hold_reject.
- new_tetromino (without game_start): used <= 0 and slots are unchanged. A simultaneous hold_input is rejected, because falling_type is stale that cycle.
- game_start has priority over new_tetromino and hold_input.
- Saturation: used never exceeds HOLDS_PER_DROP. Further holds are rejected until new_tetromino.
- Multi-slot independence: writing slot k never alters slot j != k. The same slot may be targeted repeatedly if the budget allows, and each hold returns the previous contents.
- Mid-operation reset: a pending output pulse scheduled for the next cycle is cancelled. Outputs show reset values in the cycle after rst.

Test Plan:
1. rst, NUM_SLOTS=2, HOLDS_PER_DROP=1: hold_input, sel=0, falling=T(5) -> next cycle bag_fetch=1, slot0=5, hold_valid=0, holds_left=0. Second hold_input -> hold_reject=1, slot0 still 5.
2. From 1: pulse new_tetromino, then hold sel=0, falling=I(1) -> hold_swap=1, swap_type=5, slot0=1, slot1=BLANK.
3. HOLDS_PER_DROP=2: hold sel=0 falling=3, then hold sel=1 falling=4 -> bag_fetch on both, holds_left 2->1->0. Third hold rejected.
4. hold_input with new_tetromino in the same cycle -> hold_reject=1, used=0, slots unchanged. hold_input with falling=BLANK -> hold_reject=1. NUM_SLOTS=3 with sel=3 -> hold_reject=1.
5. Slots loaded {2,6}: game_start together with hold_input -> all slots BLANK, holds_left=HOLDS_PER_DROP, no bag_fetch/hold_swap/hold_reject.
6. rst asserted in the cycle a hold is accepted -> following cycle bag_fetch=0, all slots BLANK, swap_type=BLANK.
